// File: rtl/dcpu16_mem.sv
// DCPU16 fetch-bus memory responder: word RAM behind a fixed-latency
// strobe/acknowledge slave with WAIT programmable wait states.
module dcpu16_mem #(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_adr,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    localparam logic [3:0] CNT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adr_q, adr_d;
    logic        wre_q, wre_d;
    logic [15:0] dat_q, dat_d;
    logic [15:0] dti_q, dti_d;
    logic        ack_q, ack_d;

    logic [15:0] acc_adr;
    logic        acc_wre;
    logic [15:0] acc_dat;
    logic        go;
    logic        in_rng;
    logic        mem_we;
    logic [AW-1:0] idx;

    logic [15:0] mem [2**AW];

    // With WAIT=0 the access happens on the accepting edge, so the
    // request is taken straight from the bus rather than the latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wre_d   = wre_q;
        dat_d   = dat_q;
        acc_adr = adr_q;
        acc_wre = wre_q;
        acc_dat = dat_q;
        go      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (f_stb) begin
                    adr_d   = f_adr;
                    wre_d   = f_wre;
                    dat_d   = f_dto;
                    acc_adr = f_adr;
                    acc_wre = f_wre;
                    acc_dat = f_dto;
                    if (WAIT == 0) begin
                        state_d = S_ACK;
                        go      = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACK;
                    go      = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_rng = (acc_adr >> AW) == 16'd0;
    assign idx    = acc_adr[AW-1:0];
    assign mem_we = go && acc_wre && in_rng;

    always_comb begin
        dti_d = 16'h0000;
        ack_d = go;
        if (go && !acc_wre && in_rng) begin
            dti_d = mem[idx];
        end
    end

    // RAM has no reset; a write racing an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx] <= acc_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 16'h0000;
            wre_q   <= 1'b0;
            dat_q   <= 16'h0000;
            dti_q   <= 16'h0000;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wre_q   <= wre_d;
            dat_q   <= dat_d;
            dti_q   <= dti_d;
            ack_q   <= ack_d;
        end
    end

    assign f_dti = dti_q;
    assign f_ack = ack_q;

endmodule

// File: tb/tb_dcpu16_mem.sv
// Randomised bench for dcpu16_mem: four instances (WAIT=0..3, AW=10)
// checked against an array model of the RAM and the bus latency rules.
module tb_dcpu16_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0]       stb = '0;
    logic [3:0]       wre = '0;
    logic [3:0][15:0] adr = '0;
    logic [3:0][15:0] dto = '0;
    logic [3:0][15:0] dti;
    logic [3:0]       ack;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl [4][1024];

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
    } op_t;
    op_t ops[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dcpu16_mem #(.AW(10), .WAIT(g)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .f_stb(stb[g]),
            .f_wre(wre[g]),
            .f_adr(adr[g]),
            .f_dto(dto[g]),
            .f_dti(dti[g]),
            .f_ack(ack[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_op(input int k, input bit wr,
                            input logic [15:0] a, input logic [15:0] d,
                            output logic [15:0] e);
        e = 16'h0000;
        if (a < 16'd1024) begin
            if (wr) mdl[k][a[9:0]] = d;
            else    e = mdl[k][a[9:0]];
        end
    endtask

    task automatic drive(input int k, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
        stb[k] = 1'b1;
        wre[k] = wr;
        adr[k] = a;
        dto[k] = d;
    endtask

    task automatic xfer(input int k, input bit wr,
                        input logic [15:0] a, input logic [15:0] d);
        logic [15:0] e;
        int n;
        model_op(k, wr, a, d, e);
        @(negedge clk);
        drive(k, wr, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            stb[k] = 1'b0;
        end while (!ack[k] && n < 40);
        chk("lat", n, k + 1);
        chk("dti", {16'h0, dti[k]}, {16'h0, e});
        @(negedge clk);
        chk("ack_off", {31'h0, ack[k]}, 0);
        chk("dti_off", {16'h0, dti[k]}, 0);
    endtask

    task automatic stream(input int k);
        logic [15:0] e;
        int i, cyc, last;
        i = 0;
        cyc = 0;
        last = 0;
        @(negedge clk);
        drive(k, ops[0].wr, ops[0].a, ops[0].d);
        while (i < ops.size() && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack[k]) begin
                model_op(k, ops[i].wr, ops[i].a, ops[i].d, e);
                chk("s_dti", {16'h0, dti[k]}, {16'h0, e});
                chk("s_gap", cyc - last, (i == 0) ? k + 1 : k + 2);
                last = cyc;
                i++;
                if (i < ops.size()) drive(k, ops[i].wr, ops[i].a, ops[i].d);
                else                stb[k] = 1'b0;
            end
        end
        stb[k] = 1'b0;
        chk("s_cnt", i, ops.size());
        @(negedge clk);
        chk("s_ack_off", {31'h0, ack[k]}, 0);
        ops.delete();
    endtask

    task automatic quiet(input int k, input int ncyc);
        int cnt;
        cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (ack[k]) cnt++;
        end
        chk("quiet", cnt, 0);
    endtask

    initial begin
        logic [15:0] a;
        int k, r;
        bit wr;

        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_ack", {31'h0, ack[i]}, 0);
            chk("rst_dti", {16'h0, dti[i]}, 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 32; j++)
                xfer(i, 1'b1, 16'(j), 16'($urandom));

        xfer(1, 1'b1, 16'h0012, 16'hBEEF);
        xfer(1, 1'b0, 16'h0012, 16'h0000);

        ops.push_back('{1'b1, 16'h0003, 16'h1234});
        ops.push_back('{1'b0, 16'h0003, 16'h0000});
        stream(0);

        xfer(0, 1'b1, 16'h0400, 16'hFFFF);
        xfer(0, 1'b0, 16'h0400, 16'h0000);
        xfer(0, 1'b0, 16'h0000, 16'h0000);

        xfer(3, 1'b0, 16'h0007, 16'h0000);
        quiet(3, 12);

        @(negedge clk);
        drive(3, 1'b1, 16'h0005, 16'hAAAA);
        @(posedge clk);
        @(negedge clk);
        stb[3] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstm_ack", {31'h0, ack[3]}, 0);
        chk("rstm_dti", {16'h0, dti[3]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet(3, 10);
        xfer(3, 1'b0, 16'h0005, 16'h0000);

        ops.push_back('{1'b0, 16'h0010, 16'h0000});
        ops.push_back('{1'b0, 16'h0011, 16'h0000});
        ops.push_back('{1'b0, 16'h0012, 16'h0000});
        stream(2);

        for (int it = 0; it < 80; it++) begin
            k  = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 8)       a = 16'($urandom_range(0, 31));
            else if (r == 8) a = 16'h0400 | 16'($urandom_range(0, 31));
            else             a = 16'($urandom_range(1024, 65535));
            if ($urandom_range(0, 3) == 0) begin
                ops.push_back('{wr, a, 16'($urandom)});
                ops.push_back('{1'b0, 16'($urandom_range(0, 31)), 16'h0});
                stream(k);
            end else begin
                xfer(k, wr, a, 16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
